counter_ctrl: RTL
=================

# counter_ctrl

Command-driven sequencer for the 8-bit up-counter used in the counter testbench family. Accepts count jobs (limit and one-shot/periodic mode) over a valid/ready handshake, steps the count through a prescaler, and reports wrap and completion events. Sits between a host/test sequencer and the counter datapath, owning the run/clear decisions the bench currently makes by pulsing reset by hand.

## Interface
- WIDTH, 8, counter and limit width in bits
- PRESCALE, 1, clock cycles per count step; legal range 1..256

- clk  input  1  clock, all state changes on rising edge
- reset_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  controller can accept a command; high exactly in IDLE
- cmd_limit  input  WIDTH  terminal count; value runs 0..cmd_limit
- cmd_periodic  input  1  1 = restart at 0 after limit forever; 0 = one-shot
- abort  input  1  stop the current job
- pause  input  1  hold count (present only with COUNTER_CTRL_PAUSE_EN)
- value  output  WIDTH  current count, registered
- busy  output  1  high in RUN
- wrap  output  1  one-cycle pulse when value returns from limit to 0
- done  output  1  one-cycle pulse when a job ends (one-shot completion, abort, zero limit)

## Operation
- States: IDLE, RUN. Reset → IDLE; value=0, busy=0, wrap=0, done=0, cmd_ready=1, prescaler=0.
- IDLE: accept on cmd_valid && cmd_ready. Latch limit and mode; value←0; prescaler←0.
  - limit≠0 → RUN.
  - limit=0 → stay IDLE; done=1 next cycle; no wrap.
- RUN: prescaler counts 0..PRESCALE-1; a step occurs when it equals PRESCALE-1, after which it returns to 0.
  - Step with value<limit: value←value+1.
  - Step with value==limit: value←0 and wrap=1.
    - Periodic: stay in RUN.
    - One-shot: → IDLE, with done=1 in the same cycle as wrap.
- abort in RUN → IDLE next edge: value←0, prescaler←0, done=1, wrap=0. abort wins over a simultaneous step or wrap. abort in IDLE is ignored, including in an accept cycle.
- cmd_valid while in RUN: cmd_ready=0; command is held off, not dropped by the controller.
- Arithmetic is unsigned. value never exceeds the latched limit. A limit of 2^WIDTH-1 is legal and is not an overflow.
- Asynchronous reset mid-job: immediately IDLE with all outputs at their reset values; the job is lost and no done pulse is produced.

## Timing
- Accept at edge k: busy=1, value=0 after edge k.
- First step at edge k+PRESCALE.
- One-shot, limit L: value=L after edge k+L·PRESCALE. At edge k+(L+1)·PRESCALE: value=0, wrap=done=1, busy=0.
- Periodic wrap interval: (L+1)·PRESCALE cycles.
- wrap and done are registered, one cycle wide.
- cmd_ready is high in the done cycle, so a new command can be accepted at the edge that ends that cycle (zero idle gap beyond done).
- abort sampled at edge j → busy=0, done=1 after edge j.

## Configuration
- COUNTER_CTRL_PAUSE_EN defined:
  - pause port exists.
  - pause=1 in RUN freezes the prescaler and value.
  - wrap does not fire while paused.
  - abort still takes effect while paused.
  - pause in IDLE has no effect.
- Undefined: pause port is absent and counting is never held.

## Test plan
- PRESCALE=1, one-shot limit 3 accepted at cycle 10 → value 0,1,2,3,0 over cycles 10–14; wrap=done=1 at cycle 14 only; busy high cycles 10–13.
- Periodic limit 2 with PRESCALE=4 → wrap every 12 cycles; value steps every 4 cycles; cmd_ready stays 0 while a second cmd_valid is held high.
- Abort on the exact step cycle where value=limit in periodic mode → done=1, wrap=0, value=0, IDLE.
- Limit 0 command → done pulse 1 cycle after accept; busy never asserts; next command accepted immediately.
- Async reset_n low mid-job (value=5) → value=0, busy=0, cmd_ready=1 without waiting for a clk edge; no done pulse.
- With COUNTER_CTRL_PAUSE_EN: pause for 7 cycles at value=4, limit 6 → value holds 4 throughout; completion is delayed by exactly 7 cycles.

Source files
------------

// File: rtl/counter_ctrl_if.sv
// Command/status bundle between a host sequencer and counter_ctrl.
// The pause signal exists only when COUNTER_CTRL_PAUSE_EN is defined.
interface counter_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_limit;
  logic             cmd_periodic;
  logic             abort;
`ifdef COUNTER_CTRL_PAUSE_EN
  logic             pause;
`endif
  logic [WIDTH-1:0] value;
  logic             busy;
  logic             wrap;
  logic             done;

  modport master (
`ifdef COUNTER_CTRL_PAUSE_EN
    output pause,
`endif
    output cmd_valid, cmd_limit, cmd_periodic, abort,
    input  cmd_ready, value, busy, wrap, done
  );

  modport slave (
`ifdef COUNTER_CTRL_PAUSE_EN
    input  pause,
`endif
    input  cmd_valid, cmd_limit, cmd_periodic, abort,
    output cmd_ready, value, busy, wrap, done
  );
endinterface

// File: rtl/counter_ctrl.sv
// Job sequencer for an up-counter: accepts limit/mode commands, steps through a prescaler,
// pulses wrap/done. Optional hold input enabled by COUNTER_CTRL_PAUSE_EN.
module counter_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic           clk_i,
  input  logic           reset_n_i,
  counter_ctrl_if.slave  bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PSC_MAX = PW'(PRESCALE - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             periodic_q, periodic_d;
  logic [PW-1:0]    psc_q, psc_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             hold;

`ifdef COUNTER_CTRL_PAUSE_EN
  assign hold = bus.pause;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      value_q    <= '0;
      limit_q    <= '0;
      periodic_q <= 1'b0;
      psc_q      <= '0;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
      psc_q      <= psc_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    limit_d    = limit_q;
    periodic_d = periodic_q;
    psc_d      = psc_q;
    wrap_d     = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          limit_d    = bus.cmd_limit;
          periodic_d = bus.cmd_periodic;
          value_d    = '0;
          psc_d      = '0;
          // A zero-length job finishes on the spot without ever running.
          if (bus.cmd_limit != '0) state_d = RUN;
          else                     done_d  = 1'b1;
        end
      end
      RUN: begin
        // Abort outranks any step or wrap landing on the same edge.
        if (bus.abort) begin
          state_d = IDLE;
          value_d = '0;
          psc_d   = '0;
          done_d  = 1'b1;
        end else if (!hold) begin
          if (psc_q == PSC_MAX) begin
            psc_d = '0;
            if (value_q == limit_q) begin
              value_d = '0;
              wrap_d  = 1'b1;
              if (!periodic_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              value_d = value_q + 1'b1;
            end
          end else begin
            psc_d = psc_q + PW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q == RUN);
  assign bus.value     = value_q;
  assign bus.wrap      = wrap_q;
  assign bus.done      = done_q;
endmodule
